amds_rx_scheduler: RTL and testbench
====================================

// Module: amds_rx_scheduler
// PURPOSE
//  Sequences one AMDS acquisition per timing-manager trigger: waits cfg_delay cycles, drives the AMDS
//  sync pulse, and fires start_rx to NUM_CH adc_uart_rx channels on the first sync cycle. Collects each
//  channel's assert_done pulse and signals all_done, or aborts on watchdog timeout. Sits between the
//  PWM timing manager and the adc_uart_rx instances inside the AMDS interface IP.
// PARAMETERS
//  NUM_CH  2   number of adc_uart_rx channels (data lines) sequenced, 1..8
//  CNT_W   16  width of delay/timeout/latency/statistics counters
// PORTS
//  clk             in   1       clock
//  rst_n           in   1       reset, asynchronous, active-low
//  en              in   1       gates acceptance of new triggers only
//  trigger         in   1       1-cycle acquisition request from timing manager
//  cfg_delay       in   CNT_W   cycles from trigger to sync rise (0 = next cycle)
//  cfg_sync_width  in   8       sync_out high time in cycles (0 treated as 1)
//  cfg_timeout     in   CNT_W   watchdog limit, counted from first SYNC cycle (0 = disabled)
//  rx_idle         in   NUM_CH  adc_uart_done level from each channel
//  rx_done_pulse   in   NUM_CH  assert_done pulse from each channel
//  sync_out        out  1       sync line to AMDS
//  rx_start        out  NUM_CH  1-cycle start_rx to each channel
//  busy            out  1       high in any state except IDLE
//  all_done        out  1       1-cycle pulse: every channel reported done
//  timeout_err     out  1       1-cycle pulse: watchdog abort
//  last_latency    out  CNT_W   trigger-to-all_done cycles of the last good acquisition, saturating
//  cnt_missed      out  CNT_W   triggers dropped (wraps)
//  cnt_timeout     out  CNT_W   watchdog aborts (wraps)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; done mask, timers, counters cleared.
//  States: IDLE -> DELAY -> SYNC -> WAIT_RX -> DONE -> IDLE.
//   IDLE: trigger&en&(&rx_idle) -> DELAY with delay timer = cfg_delay; if cfg_delay==0 go straight to SYNC.
//    trigger&en with any rx_idle low -> stay IDLE, cnt_missed+1. trigger with en=0: ignored, not counted.
//   DELAY: decrement each cycle; at 1 -> SYNC.
//   SYNC: sync_out=1 for max(cfg_sync_width,1) cycles; rx_start=all ones on first SYNC cycle only;
//    done mask cleared same cycle; watchdog starts. Last sync cycle -> WAIT_RX (sync_out drops).
//   WAIT_RX: rx_done_pulse[i] sets mask[i] (sticky). Mask all-ones (incl. pulses this cycle) -> DONE.
//   DONE: all_done=1 for this cycle, last_latency latched, -> IDLE.
//  Watchdog: counts in SYNC and WAIT_RX; reaching cfg_timeout -> timeout_err pulse, cnt_timeout+1, IDLE.
//  Simultaneous: mask completes same cycle as expiry -> completion wins (no timeout_err).
//   Done pulse in first SYNC cycle: clear wins, pulse discarded.
//  Trigger in any non-IDLE state (incl. DONE) -> dropped, cnt_missed+1.
//  Latency counter: starts 1 on trigger-accept cycle, +1 per cycle, saturates at all-ones.
//  en deasserted mid-acquisition: in-flight sequence runs to DONE or timeout.
//  Mid-operation async reset: immediate return to reset values; sync_out drops asynchronously.
//  All outputs registered; config sampled only at trigger accept (delay) and SYNC entry (width, timeout).
// STRUCTURE
//  amds_sched_pkg: state enum (IDLE, DELAY, SYNC, WAIT_RX, DONE), CNT_W default, NUM_CH max.
//  Sub-module amds_sched_timer: loadable down-counter with zero flag; one each for delay, sync, watchdog.
//  Top: FSM, sticky done mask, latency/stat counters.
// TESTING
//  1 delay=10,width=4,NUM_CH=2, both done 50 cycles later -> sync high cycles 11-14, rx_start@11, all_done.
//  2 delay=0 -> sync_out and rx_start on cycle after trigger; latency counted from trigger cycle.
//  3 timeout=100, only ch0 done -> timeout_err@100 after SYNC, cnt_timeout=1, no all_done, busy=0.
//  4 trigger during WAIT_RX and during DONE -> cnt_missed=2, current acquisition completes normally.
//  5 ch1 done pulse same cycle as watchdog expiry -> all_done, no timeout_err, cnt_timeout unchanged.
//  6 rx_idle[1]=0 at trigger -> no sync_out, cnt_missed+1; rst_n low in SYNC -> sync_out 0, state IDLE.

Source files
------------

// File: rtl/amds_sched_pkg.sv
// amds_sched_pkg
//   Shared types and constants for the AMDS receive scheduler.
//   - sched_state_t : acquisition sequencer states
//   - CNT_W_DEF     : default width of delay/timeout/latency/statistics counters
//   - NUM_CH_DEF    : default number of adc_uart_rx channels
//   - NUM_CH_MAX    : largest supported channel count
//   - SYNC_W        : width of the sync high-time configuration
package amds_sched_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int NUM_CH_DEF = 2;
    localparam int NUM_CH_MAX = 8;
    localparam int SYNC_W     = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DELAY   = 3'd1,
        SYNC    = 3'd2,
        WAIT_RX = 3'd3,
        DONE    = 3'd4
    } sched_state_t;

endpackage

// File: rtl/amds_sched_timer.sv
// amds_sched_timer
//   Loadable down-counter with a zero flag. The count stops at zero.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     load        load load_val this cycle (has priority over dec)
//     load_val    value to load
//     dec         decrement by one when the count is non-zero
//     zero        count is zero
module amds_sched_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/amds_rx_scheduler.sv
// amds_rx_scheduler
//   Sequences one AMDS acquisition per timing-manager trigger: programmable
//   delay, sync pulse, start of all adc_uart_rx channels, collection of their
//   done pulses, and watchdog abort.
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset
//     en               gates acceptance of new triggers
//     trigger          1-cycle acquisition request
//     cfg_delay        cycles from trigger to sync rise (0 = next cycle)
//     cfg_sync_width   sync high time in cycles (0 behaves as 1)
//     cfg_timeout      watchdog limit from first sync cycle (0 = disabled)
//     rx_idle          per-channel idle level
//     rx_done_pulse    per-channel done pulse
//     sync_out         sync line to AMDS
//     rx_start         1-cycle start to every channel
//     busy             sequencer not idle
//     all_done         1-cycle pulse, every channel reported done
//     timeout_err      1-cycle pulse, watchdog abort
//     last_latency     trigger-to-done cycles of the last good acquisition
//     cnt_missed       dropped triggers (wraps)
//     cnt_timeout      watchdog aborts (wraps)
//
//   state   | meaning
//   IDLE    | waiting for an accepted trigger
//   DELAY   | counting cfg_delay cycles before sync
//   SYNC    | sync_out high; channels started on the first cycle
//   WAIT_RX | collecting channel done pulses under the watchdog
//   DONE    | all channels reported; all_done pulse, latency latched
module amds_rx_scheduler
    import amds_sched_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              trigger,
    input  logic [CNT_W-1:0]  cfg_delay,
    input  logic [SYNC_W-1:0] cfg_sync_width,
    input  logic [CNT_W-1:0]  cfg_timeout,
    input  logic [NUM_CH-1:0] rx_idle,
    input  logic [NUM_CH-1:0] rx_done_pulse,
    output logic              sync_out,
    output logic [NUM_CH-1:0] rx_start,
    output logic              busy,
    output logic              all_done,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  last_latency,
    output logic [CNT_W-1:0]  cnt_missed,
    output logic [CNT_W-1:0]  cnt_timeout
);

    generate
        if (NUM_CH < 1 || NUM_CH > NUM_CH_MAX) begin : g_num_ch_range
            $error("amds_rx_scheduler: NUM_CH out of range");
        end
    endgenerate

    sched_state_t state, state_next;

    logic accept, miss, sync_entry, tmo;
    logic first_sync, wd_en;
    logic delay_zero, sync_zero, wd_zero;
    logic [NUM_CH-1:0] mask;
    logic [CNT_W-1:0]  lat_cnt, lat_inc;
    logic [CNT_W-1:0]  delay_load_val, wd_load_val;
    logic [SYNC_W-1:0] sync_load_val;
    logic trig_ok, mask_full, wd_expire;

    assign trig_ok   = trigger & en;
    // Pulses arriving this cycle count toward completion.
    assign mask_full = &(mask | rx_done_pulse);
    assign wd_expire = wd_en & wd_zero;
    assign lat_inc   = (&lat_cnt) ? lat_cnt : lat_cnt + CNT_W'(1);

    // Timers are loaded with N-1 so the zero flag marks the final cycle.
    assign delay_load_val = cfg_delay - CNT_W'(1);
    assign sync_load_val  = (cfg_sync_width == '0) ? '0 : cfg_sync_width - SYNC_W'(1);
    assign wd_load_val    = (cfg_timeout == '0) ? '0 : cfg_timeout - CNT_W'(1);

    amds_sched_timer #(.W(CNT_W)) u_delay_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (delay_load_val),
        .dec      (state == DELAY),
        .zero     (delay_zero)
    );

    amds_sched_timer #(.W(SYNC_W)) u_sync_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sync_entry),
        .load_val (sync_load_val),
        .dec      (state == SYNC),
        .zero     (sync_zero)
    );

    amds_sched_timer #(.W(CNT_W)) u_wd_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sync_entry),
        .load_val (wd_load_val),
        .dec      ((state == SYNC) || (state == WAIT_RX)),
        .zero     (wd_zero)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        miss       = 1'b0;
        sync_entry = 1'b0;
        tmo        = 1'b0;
        case (state)
            IDLE: begin
                if (trig_ok) begin
                    if (&rx_idle) begin
                        accept = 1'b1;
                        if (cfg_delay == '0) begin
                            state_next = SYNC;
                            sync_entry = 1'b1;
                        end else begin
                            state_next = DELAY;
                        end
                    end else begin
                        miss = 1'b1;
                    end
                end
            end
            DELAY: begin
                miss = trig_ok;
                if (delay_zero) begin
                    state_next = SYNC;
                    sync_entry = 1'b1;
                end
            end
            SYNC: begin
                miss = trig_ok;
                if (wd_expire) begin
                    state_next = IDLE;
                    tmo        = 1'b1;
                end else if (sync_zero) begin
                    state_next = WAIT_RX;
                end
            end
            WAIT_RX: begin
                miss = trig_ok;
                // Completion beats a watchdog expiry in the same cycle.
                if (mask_full) begin
                    state_next = DONE;
                end else if (wd_expire) begin
                    state_next = IDLE;
                    tmo        = 1'b1;
                end
            end
            DONE: begin
                miss       = trig_ok;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            first_sync   <= 1'b0;
            wd_en        <= 1'b0;
            mask         <= '0;
            lat_cnt      <= '0;
            sync_out     <= 1'b0;
            rx_start     <= '0;
            busy         <= 1'b0;
            all_done     <= 1'b0;
            timeout_err  <= 1'b0;
            last_latency <= '0;
            cnt_missed   <= '0;
            cnt_timeout  <= '0;
        end else begin
            state       <= state_next;
            first_sync  <= sync_entry;
            sync_out    <= (state_next == SYNC);
            rx_start    <= {NUM_CH{sync_entry}};
            busy        <= (state_next != IDLE);
            all_done    <= (state_next == DONE);
            timeout_err <= tmo;

            if (sync_entry) begin
                wd_en <= (cfg_timeout != '0);
            end

            // Channel starts on the first sync cycle, so anything seen then is stale.
            if ((state == SYNC) && first_sync) begin
                mask <= '0;
            end else if ((state == SYNC) || (state == WAIT_RX)) begin
                mask <= mask | rx_done_pulse;
            end

            // lat_cnt holds the 1-based cycle index since the trigger-accept cycle.
            if (accept) begin
                lat_cnt <= CNT_W'(2);
            end else if (state != IDLE) begin
                lat_cnt <= lat_inc;
            end

            if ((state_next == DONE) && (state != DONE)) begin
                last_latency <= lat_inc;
            end

            if (miss) begin
                cnt_missed <= cnt_missed + CNT_W'(1);
            end
            if (tmo) begin
                cnt_timeout <= cnt_timeout + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_amds_rx_scheduler.sv
module tb_amds_rx_scheduler;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 16;
    localparam int K_START = 0;
    localparam int K_DONE  = 1;
    localparam int K_TMO   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              trigger;
    logic [CNT_W-1:0]  cfg_delay;
    logic [7:0]        cfg_sync_width;
    logic [CNT_W-1:0]  cfg_timeout;
    logic [NUM_CH-1:0] rx_idle;
    logic [NUM_CH-1:0] rx_done_pulse;
    logic              sync_out;
    logic [NUM_CH-1:0] rx_start;
    logic              busy;
    logic              all_done;
    logic              timeout_err;
    logic [CNT_W-1:0]  last_latency;
    logic [CNT_W-1:0]  cnt_missed;
    logic [CNT_W-1:0]  cnt_timeout;

    amds_rx_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .trigger        (trigger),
        .cfg_delay      (cfg_delay),
        .cfg_sync_width (cfg_sync_width),
        .cfg_timeout    (cfg_timeout),
        .rx_idle        (rx_idle),
        .rx_done_pulse  (rx_done_pulse),
        .sync_out       (sync_out),
        .rx_start       (rx_start),
        .busy           (busy),
        .all_done       (all_done),
        .timeout_err    (timeout_err),
        .last_latency   (last_latency),
        .cnt_missed     (cnt_missed),
        .cnt_timeout    (cnt_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;
    ev_t sbq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int at, input int val);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        e.val  = val;
        sbq.push_back(e);
    endtask

    task automatic pop_check(input string tag, input int kind, input logic [31:0] val);
        ev_t e;
        total++;
        assert (sbq.size() != 0) else begin
            bad++;
            $error("FAIL %s observed=unexpected_event expected=none at_cycle=%0d", tag, cyc);
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check({tag, "_kind"}, kind, e.kind);
            check({tag, "_cycle"}, cyc, e.cyc);
            check({tag, "_value"}, val, e.val);
        end
    endtask

    // Output-event monitor: every start/done/timeout pulse must match the next expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rx_start !== '0) pop_check("ev_rx_start", K_START, 32'(rx_start));
            if (all_done !== 1'b0) pop_check("ev_all_done", K_DONE, 32'(last_latency));
            if (timeout_err !== 1'b0) pop_check("ev_timeout", K_TMO, 32'(cnt_timeout));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int c0;
        int missed_exp;

        rst_n          = 1'b0;
        en             = 1'b1;
        trigger        = 1'b0;
        cfg_delay      = '0;
        cfg_sync_width = 8'd1;
        cfg_timeout    = '0;
        rx_idle        = '1;
        rx_done_pulse  = '0;
        missed_exp     = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_sync_out", sync_out, 0);
        check("rst_rx_start", rx_start, 0);
        check("rst_busy", busy, 0);
        check("rst_all_done", all_done, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_last_latency", last_latency, 0);
        check("rst_cnt_missed", cnt_missed, 0);
        check("rst_cnt_timeout", cnt_timeout, 0);
        rst_n = 1'b1;
        step();
        step();

        // 1: delay 10, width 4, both channels done 50 cycles after start
        cfg_delay = 16'd10; cfg_sync_width = 8'd4; cfg_timeout = '0;
        c0 = cyc;
        trigger = 1'b1;
        push_ev(K_START, c0 + 11, 3);
        step();
        trigger = 1'b0;
        check("t1_busy", busy, 1);
        for (int k = 1; k <= 16; k++) begin
            check($sformatf("t1_sync_c%0d", k), sync_out, (k >= 11 && k <= 14) ? 1 : 0);
            step();
        end
        run_to(c0 + 61);
        rx_done_pulse = 2'b11;
        push_ev(K_DONE, c0 + 62, 63);
        step();
        rx_done_pulse = '0;
        step();
        check("t1_busy_end", busy, 0);
        check("t1_cnt_missed", cnt_missed, 0);

        // 2: delay 0, width 1; done pulse in first sync cycle is discarded
        cfg_delay = '0; cfg_sync_width = 8'd1; cfg_timeout = '0;
        step();
        c0 = cyc;
        trigger = 1'b1;
        push_ev(K_START, c0 + 1, 3);
        step();
        trigger = 1'b0;
        check("t2_sync_first", sync_out, 1);
        rx_done_pulse = 2'b01;
        step();
        rx_done_pulse = '0;
        check("t2_sync_drop", sync_out, 0);
        run_to(c0 + 4);
        rx_done_pulse = 2'b10;
        step();
        rx_done_pulse = '0;
        run_to(c0 + 6);
        check("t2_still_busy", busy, 1);
        rx_done_pulse = 2'b01;
        push_ev(K_DONE, c0 + 7, 8);
        step();
        rx_done_pulse = '0;
        step();
        check("t2_busy_end", busy, 0);

        // 3: watchdog 100, only ch0 reports
        cfg_delay = 16'd2; cfg_sync_width = 8'd4; cfg_timeout = 16'd100;
        step();
        c0 = cyc;
        trigger = 1'b1;
        push_ev(K_START, c0 + 3, 3);
        step();
        trigger = 1'b0;
        run_to(c0 + 20);
        rx_done_pulse = 2'b01;
        step();
        rx_done_pulse = '0;
        push_ev(K_TMO, c0 + 103, 1);
        run_to(c0 + 102);
        check("t3_busy_before_expiry", busy, 1);
        step();
        check("t3_busy_after_expiry", busy, 0);
        check("t3_sync_out", sync_out, 0);
        step();
        check("t3_cnt_timeout", cnt_timeout, 1);

        // 4: triggers during WAIT_RX and DONE are dropped
        cfg_delay = 16'd1; cfg_sync_width = 8'd1; cfg_timeout = '0;
        step();
        c0 = cyc;
        trigger = 1'b1;
        push_ev(K_START, c0 + 2, 3);
        step();
        trigger = 1'b0;
        run_to(c0 + 5);
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        run_to(c0 + 8);
        rx_done_pulse = 2'b11;
        push_ev(K_DONE, c0 + 9, 10);
        step();
        rx_done_pulse = '0;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        missed_exp = missed_exp + 2;
        check("t4_cnt_missed", cnt_missed, missed_exp);
        check("t4_busy_end", busy, 0);

        // 5: last channel done in the watchdog-expiry cycle: completion wins
        cfg_delay = '0; cfg_sync_width = 8'd2; cfg_timeout = 16'd20;
        step();
        c0 = cyc;
        trigger = 1'b1;
        push_ev(K_START, c0 + 1, 3);
        step();
        trigger = 1'b0;
        run_to(c0 + 5);
        rx_done_pulse = 2'b01;
        step();
        rx_done_pulse = '0;
        run_to(c0 + 20);
        rx_done_pulse = 2'b10;
        push_ev(K_DONE, c0 + 21, 22);
        step();
        rx_done_pulse = '0;
        step();
        check("t5_cnt_timeout", cnt_timeout, 1);
        check("t5_busy_end", busy, 0);

        // 6a: a channel not idle at trigger -> dropped and counted
        cfg_delay = '0; cfg_sync_width = 8'd1; cfg_timeout = '0;
        rx_idle = 2'b01;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        rx_idle = '1;
        check("t6_no_sync", sync_out, 0);
        check("t6_not_busy", busy, 0);
        step();
        missed_exp = missed_exp + 1;
        check("t6_cnt_missed", cnt_missed, missed_exp);

        // 6b: trigger with en low is ignored and not counted
        en = 1'b0;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        en = 1'b1;
        step();
        check("t6_en_low_missed", cnt_missed, missed_exp);
        check("t6_en_low_busy", busy, 0);

        // 6c: asynchronous reset while in SYNC
        cfg_delay = '0; cfg_sync_width = 8'd10; cfg_timeout = '0;
        c0 = cyc;
        trigger = 1'b1;
        push_ev(K_START, c0 + 1, 3);
        step();
        trigger = 1'b0;
        step();
        step();
        check("t6_sync_high", sync_out, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_sync_out", sync_out, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_cnt_missed", cnt_missed, 0);
        check("t6_rst_cnt_timeout", cnt_timeout, 0);
        check("t6_rst_last_latency", last_latency, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        step();
        check("t6_post_rst_busy", busy, 0);
        check("t6_post_rst_sync", sync_out, 0);

        check("sb_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
